// File: rtl/tile_pkg.sv
// Shared types and constants for the tile renderer.
// Optional grid overlay is selected by TILE_RENDERER_GRID_LINES_EN.
package tile_pkg;

    localparam int TILE_SHIFT = 5;
    localparam int MAP_W      = 20;
    localparam int MAP_H      = 15;
    localparam int MAP_SIZE   = MAP_W * MAP_H;
    localparam int LATENCY    = 2;
    localparam int AW         = 9;

    localparam logic [AW-1:0] MAP_LAST = AW'(MAP_SIZE - 1);
    localparam logic [AW-1:0] MAP_LIM  = AW'(MAP_SIZE);

    typedef logic [2:0] tile_t;

    localparam tile_t TILE_EMPTY = 3'd0;
    localparam tile_t TILE_WALL  = 3'd1;
    localparam tile_t TILE_PIPE  = 3'd2;
    localparam tile_t TILE_DIRT  = 3'd3;
    localparam tile_t TILE_ROBOT = 3'd4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_EMPTY   = {8'd0,   8'd0,   8'd0};
    localparam rgb_t RGB_WALL    = {8'd128, 8'd128, 8'd128};
    localparam rgb_t RGB_PIPE    = {8'd0,   8'd0,   8'd255};
    localparam rgb_t RGB_DIRT    = {8'd139, 8'd69,  8'd19};
    localparam rgb_t RGB_ROBOT   = {8'd255, 8'd255, 8'd0};
    localparam rgb_t RGB_INVALID = {8'd255, 8'd0,   8'd255};
    localparam rgb_t GRID_RGB    = {8'd64,  8'd64,  8'd64};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Robot sprite occupies the inner 24x24 square of its tile.
    function automatic rgb_t tile_rgb(tile_t t, logic [4:0] ox,
                                      logic [4:0] oy);
        rgb_t c;
        c = RGB_INVALID;
        case (t)
            TILE_EMPTY: c = RGB_EMPTY;
            TILE_WALL:  c = RGB_WALL;
            TILE_PIPE:  c = RGB_PIPE;
            TILE_DIRT:  c = RGB_DIRT;
            TILE_ROBOT: begin
                if (ox >= 5'd4 && ox <= 5'd27 &&
                    oy >= 5'd4 && oy <= 5'd27)
                    c = RGB_ROBOT;
                else
                    c = RGB_EMPTY;
            end
            default:    c = RGB_INVALID;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// Pixel stream, tile-map write port and VGA outputs of the tile renderer.
// master drives pixels/writes; slave is the renderer.
interface tile_renderer_if
    import tile_pkg::*;
;
    logic          video_on;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          hs_in;
    logic          vs_in;
    logic          map_we;
    logic [AW-1:0] map_addr;
    tile_t         map_data;
    logic          init_busy;
    logic          vga_hs;
    logic          vga_vs;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;

    modport master (
        output video_on, pixel_x, pixel_y, hs_in, vs_in,
        output map_we, map_addr, map_data,
        input  init_busy, vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

    modport slave (
        input  video_on, pixel_x, pixel_y, hs_in, vs_in,
        input  map_we, map_addr, map_data,
        output init_busy, vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

endinterface

// File: rtl/tile_map_ram.sv
// 300x3 tile map: one write port, one synchronous read-first read port.
// Storage has no reset; the renderer clears it after reset.
module tile_map_ram
    import tile_pkg::*;
(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  tile_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output tile_t         rdata_o
);

    tile_t mem [MAP_SIZE];
    tile_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i < MAP_LIM)
            mem[waddr_i] <= wdata_i;
        // Off-map indices only occur outside active video.
        if (raddr_i < MAP_LIM)
            rdata_q <= mem[raddr_i];
        else
            rdata_q <= TILE_EMPTY;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_renderer.sv
// Tile-map pixel renderer: 2-clock pipeline from pixel coordinate to RGB.
// Define TILE_RENDERER_GRID_LINES_EN to overlay grey tile grid lines.
module tile_renderer
    import tile_pkg::*;
(
    input  logic clock_25,
    input  logic reset_key,
    tile_renderer_if.slave bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_q, clr_d;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    tile_t         ram_wd;
    tile_t         ram_rd;

    logic [AW-1:0] idx_d, idx_q;
    logic [4:0]    ox1_q, oy1_q, ox2_q, oy2_q;
    logic          von1_q, von2_q;
    logic          hs1_q, hs2_q, vs1_q, vs2_q;
    rgb_t          pix;
    logic          unused_ok;

    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            state_q <= ST_INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        ram_we  = 1'b0;
        ram_wa  = bus.map_addr;
        ram_wd  = bus.map_data;
        unique case (state_q)
            ST_INIT: begin
                ram_we = 1'b1;
                ram_wa = clr_q;
                ram_wd = TILE_EMPTY;
                clr_d  = clr_q + 1'b1;
                if (clr_q == MAP_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                ram_we = bus.map_we && (bus.map_addr < MAP_LIM);
            end
        endcase
    end

    assign idx_d = AW'(bus.pixel_y[8:TILE_SHIFT]) * AW'(MAP_W)
                 + AW'(bus.pixel_x[9:TILE_SHIFT]);

    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            idx_q  <= '0;
            ox1_q  <= '0;
            oy1_q  <= '0;
            von1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            ox2_q  <= '0;
            oy2_q  <= '0;
            von2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            idx_q  <= idx_d;
            ox1_q  <= bus.pixel_x[4:0];
            oy1_q  <= bus.pixel_y[4:0];
            von1_q <= bus.video_on;
            hs1_q  <= bus.hs_in;
            vs1_q  <= bus.vs_in;
            ox2_q  <= ox1_q;
            oy2_q  <= oy1_q;
            von2_q <= von1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    tile_map_ram u_ram (
        .clk_i   (clock_25),
        .we_i    (ram_we),
        .waddr_i (ram_wa),
        .wdata_i (ram_wd),
        .raddr_i (idx_q),
        .rdata_o (ram_rd)
    );

    always_comb begin
        pix = RGB_EMPTY;
        if (von2_q && state_q == ST_RUN) begin
            pix = tile_rgb(ram_rd, ox2_q, oy2_q);
`ifdef TILE_RENDERER_GRID_LINES_EN
            if (ox2_q == 5'd0 || oy2_q == 5'd0)
                pix = GRID_RGB;
`else
`endif
        end
    end

    assign bus.init_busy = (state_q == ST_INIT);
    assign bus.vga_hs    = hs2_q;
    assign bus.vga_vs    = vs2_q;
    assign bus.vga_r     = pix.r;
    assign bus.vga_g     = pix.g;
    assign bus.vga_b     = pix.b;

    assign unused_ok = bus.pixel_y[9];

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: expected {hs,vs,rgb} queued per pixel.
// Grid expectations follow TILE_RENDERER_GRID_LINES_EN.
module tb_tile_renderer;
    import tile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    tile_renderer_if bus ();

    tile_renderer dut (
        .clock_25  (clk),
        .reset_key (rst_n),
        .bus       (bus)
    );

    typedef struct {
        string       tag;
        logic [25:0] exp;
    } sb_t;

    sb_t        sbq[$];
    logic [2:0] mdl [300];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_rgb(int x, int y, bit von,
                                            bit blank);
        int          idx;
        logic [4:0]  ox, oy;
        logic [2:0]  t;
        logic [23:0] c;
        if (!von || blank) return 24'h0;
        ox  = 5'(x % 32);
        oy  = 5'(y % 32);
        idx = (y / 32) * 20 + (x / 32);
        t   = mdl[idx];
        case (t)
            3'd0: c = 24'h000000;
            3'd1: c = 24'h808080;
            3'd2: c = 24'h0000ff;
            3'd3: c = {8'd139, 8'd69, 8'd19};
            3'd4: c = (ox >= 4 && ox <= 27 && oy >= 4 && oy <= 27)
                      ? 24'hffff00 : 24'h000000;
            default: c = 24'hff00ff;
        endcase
`ifdef TILE_RENDERER_GRID_LINES_EN
        if (ox == 0 || oy == 0) c = 24'h404040;
`endif
        return c;
    endfunction

    // Called at a falling edge: score the output due now, drive next pixel.
    task automatic step(string tag, bit von, int x, int y,
                        bit we = 0, int addr = 0, int data = 0);
        sb_t  e;
        logic hs, vs;
        if (sbq.size() == 2) begin
            e = sbq.pop_front();
            chk(e.tag, {6'd0, bus.vga_hs, bus.vga_vs,
                        bus.vga_r, bus.vga_g, bus.vga_b}, {6'd0, e.exp});
        end
        if (we && cyc >= 300 && addr < 300) mdl[addr] = data[2:0];
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        bus.video_on = von;
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.hs_in    = hs;
        bus.vs_in    = vs;
        bus.map_we   = we;
        bus.map_addr = 9'(addr);
        bus.map_data = 3'(data);
        e.tag = tag;
        e.exp = {hs, vs, ref_rgb(x, y, von, (cyc + 2) < 300)};
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic init_phase(string tag);
        int n = 0;
        for (int i = 0; i < 320; i++) begin
            if (bus.init_busy) n++;
            step("init_pix", 1, int'($urandom_range(0, 639)),
                 int'($urandom_range(0, 479)),
                 1, int'($urandom_range(0, 299)), 1);
        end
        chk(tag, n, 300);
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_rgb"}, {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
        chk({tag, "_sync"}, {bus.vga_hs, bus.vga_vs}, 2'b11);
        chk({tag, "_busy"}, bus.init_busy, 1);
    endtask

    initial begin
        bus.video_on = 0;
        bus.pixel_x  = 0;
        bus.pixel_y  = 0;
        bus.hs_in    = 1;
        bus.vs_in    = 1;
        bus.map_we   = 0;
        bus.map_addr = 0;
        bus.map_data = 0;
        foreach (mdl[i]) mdl[i] = 3'd0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        init_phase("init_len");

        step("wr21", 0, 0, 0, 1, 21, 2);
        step("pipe", 1, 40, 40);
        step("empty", 1, 10, 10);
        step("wr0", 0, 0, 0, 1, 0, 4);
        step("rob_out", 1, 2, 2);
        step("rob_in", 1, 16, 16);
        step("rob_lo", 1, 4, 4);
        step("rob_hi", 1, 27, 27);
        step("rob_edge", 1, 28, 4);
        step("wr300", 0, 0, 0, 1, 300, 1);
        for (int tx = 0; tx < 20; tx++)
            step("row0", 1, tx * 32 + 16, 16);
        step("grid_a", 1, 32, 40);
        step("grid_b", 1, 33, 40);
        step("voff", 0, 40, 40);
        step("old5", 1, 160, 0);
        step("new5", 1, 170, 5, 1, 5, 1);
        step("new5b", 1, 165, 10);

        for (int i = 0; i < 300; i++)
            step("rand", $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 310)),
                 int'($urandom_range(0, 7)));

        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        sbq.delete();
        foreach (mdl[i]) mdl[i] = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        init_phase("reinit_len");
        for (int ty = 0; ty < 15; ty++)
            for (int tx = 0; tx < 20; tx++)
                step("post_rst", 1, tx * 32 + 16, ty * 32 + 16);

        repeat (3) step("flush", 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
